// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the execution back end.
// Holds data/register widths, the commit unit count, the commit entry layout
// and the fixed unit numbering used on the commit arbiter ports.
package core_config_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int COMMIT_UNITS = 4;

  // One completed result as it sits in the writeback slot.
  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  error;
  } commit_entry_t;

  // Port position of each execution unit on the commit arbiter.
  typedef enum logic [2:0] {
    UNIT_ALU0   = 3'd0,
    UNIT_ALU1   = 3'd1,
    UNIT_SHIFT  = 3'd2,
    UNIT_MULDIV = 3'd3
  } unit_idx_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
// Latency: grant is combinational; last_grant moves at the edge when advance_i is high.
// Backpressure: with advance_i low the priority pointer holds, so a stalled winner keeps its turn.
module rr_arbiter
  import core_config_pkg::*;
#(
  parameter int N = COMMIT_UNITS
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N-1:0]                        req_i,
  input  logic                                advance_i,
  output logic [N-1:0]                        gnt_oh_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx_o,
  output logic                                gnt_vld_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] last_q;
  logic [N-1:0]     hi_req;
  logic [N-1:0]     pick;

  // Prefer requesters above the last winner; fall back to the lowest requester to wrap.
  always_comb begin
    hi_req    = '0;
    gnt_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      hi_req[i] = req_i[i] && (i > int'(last_q));
    end
    pick = (|hi_req) ? hi_req : req_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt_idx_o = IDX_W'(i);
      end
    end
    gnt_vld_o = |req_i;
    gnt_oh_o  = gnt_vld_o ? (N'(1) << gnt_idx_o) : '0;
  end

  // Remember the winner only when the grant is actually consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= IDX_W'(N - 1);
    end else if (advance_i) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/commit_arbiter.sv
// Commit arbiter: picks one finished unit result per cycle into a single writeback slot.
// Latency: one cycle from candidate to wb_we / u_clear / exc_valid.
// Backpressure: a full slot with wb_ready low blocks grants and holds wb_*; drain and load overlap.
module commit_arbiter
  import core_config_pkg::*;
#(
  parameter int N_UNITS    = COMMIT_UNITS,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_UNITS*XLEN-1:0]       u_res,
  input  logic [N_UNITS*REG_ADDR_W-1:0] u_rd,
  input  logic [N_UNITS-1:0]            u_valid,
  input  logic [N_UNITS-1:0]            u_error,
  input  logic [N_UNITS-1:0]            u_req,
  output logic [N_UNITS-1:0]            u_clear,
  input  logic                          wb_ready,
  output logic                          wb_we,
  output logic [REG_ADDR_W-1:0]         wb_addr,
  output logic [XLEN-1:0]               wb_data,
  output logic                          exc_valid,
  output logic [2:0]                    exc_unit,
  output logic [REG_ADDR_W-1:0]         exc_rd,
  input  logic                          flush
);

  localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  logic [N_UNITS-1:0]    cand;
  logic [N_UNITS-1:0]    gnt_oh;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_vld;
  logic                  can_load;
  logic                  advance;

  logic [XLEN-1:0]       win_res;
  logic [REG_ADDR_W-1:0] win_rd;
  logic                  win_err;

  logic                  wb_full_q,   wb_full_d;
  logic [REG_ADDR_W-1:0] wb_addr_q,   wb_addr_d;
  logic [XLEN-1:0]       wb_data_q,   wb_data_d;
  logic [N_UNITS-1:0]    u_clear_q,   u_clear_d;
  logic                  exc_valid_q, exc_valid_d;
  logic [2:0]            exc_unit_q,  exc_unit_d;
  logic [REG_ADDR_W-1:0] exc_rd_q,    exc_rd_d;

  // A unit being cleared this cycle still shows req; mask it so it cannot win twice.
  assign cand     = u_req & u_valid & ~u_clear_q;
  assign can_load = !wb_full_q || wb_ready;
  assign advance  = can_load && gnt_vld && !flush;

  rr_arbiter #(
    .N (N_UNITS)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (cand),
    .advance_i (advance),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Steer the granted unit's result onto the capture path.
  always_comb begin
    win_res = '0;
    win_rd  = '0;
    win_err = 1'b0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (gnt_oh[i]) begin
        win_res = u_res[i*XLEN +: XLEN];
        win_rd  = u_rd[i*REG_ADDR_W +: REG_ADDR_W];
        win_err = u_error[i];
      end
    end
  end

  // Slot, clear and exception next state; flush wins over drain and capture.
  always_comb begin
    wb_full_d   = wb_full_q && !wb_ready;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    u_clear_d   = '0;
    exc_valid_d = 1'b0;
    exc_unit_d  = exc_unit_q;
    exc_rd_d    = exc_rd_q;
    if (flush) begin
      wb_full_d = 1'b0;
      u_clear_d = '1;
    end else if (advance) begin
      u_clear_d = gnt_oh;
      if (win_err) begin
        // Erroring results never reach the register file; the slot is left as drained.
        exc_valid_d = 1'b1;
        exc_unit_d  = 3'(gnt_idx);
        exc_rd_d    = win_rd;
      end else if (win_rd != '0) begin
        wb_full_d = 1'b1;
        wb_addr_d = win_rd;
        wb_data_d = win_res;
      end
    end
  end

  // State registers with synchronous reset dropping any buffered entry and pending clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_full_q   <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      u_clear_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_unit_q  <= '0;
      exc_rd_q    <= '0;
    end else begin
      wb_full_q   <= wb_full_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      u_clear_q   <= u_clear_d;
      exc_valid_q <= exc_valid_d;
      exc_unit_q  <= exc_unit_d;
      exc_rd_q    <= exc_rd_d;
    end
  end

  assign wb_we     = wb_full_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign u_clear   = u_clear_q;
  assign exc_valid = exc_valid_q;
  assign exc_unit  = exc_unit_q;
  assign exc_rd    = exc_rd_q;

endmodule

// File: tb/tb_commit_arbiter.sv
// Bench for commit_arbiter: directed scenarios then random traffic.
// Expected writes, clears and exceptions come from a behavioural model into queues;
// a monitor pops and compares them as the DUT presents each event.
module tb_commit_arbiter;
  import core_config_pkg::*;

  localparam int N  = 4;
  localparam int XW = 32;
  localparam int AW = 5;

  logic            clk;
  logic            rst_n;
  logic [N*XW-1:0] u_res;
  logic [N*AW-1:0] u_rd;
  logic [N-1:0]    u_valid, u_error, u_req, u_clear;
  logic            wb_ready, wb_we, exc_valid, flush;
  logic [AW-1:0]   wb_addr, exc_rd;
  logic [XW-1:0]   wb_data;
  logic [2:0]      exc_unit;

  commit_arbiter dut (
    .clk(clk), .rst_n(rst_n), .u_res(u_res), .u_rd(u_rd), .u_valid(u_valid),
    .u_error(u_error), .u_req(u_req), .u_clear(u_clear), .wb_ready(wb_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .exc_valid(exc_valid),
    .exc_unit(exc_unit), .exc_rd(exc_rd), .flush(flush)
  );

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  // 0: register writes, 1: clear pulses, 2: exceptions
  ev_t evq[3][$];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic rst_at_edge = 1'b1;

  // Unit emulation
  commit_entry_t ue[N];
  bit            upend[N];
  bit            udrop[N];
  bit            uregen[N];
  int            regen_pct = 100;
  bit            rand_faults = 1'b0;

  // Reference model state
  bit            m_full = 1'b0;
  commit_entry_t m_ent;
  int            m_last = N - 1;
  logic [N-1:0]  m_clear = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
  end

  function automatic string qname(int qi);
    case (qi)
      0:       return "write";
      1:       return "clear";
      default: return "exception";
    endcase
  endfunction

  task automatic load_unit(int i, logic [31:0] data, logic [4:0] rd, bit err);
    ue[i]    = '{data: data, rd: rd, error: err};
    upend[i] = 1'b1;
    udrop[i] = 1'b0;
  endtask

  task automatic new_result(int i);
    logic [4:0] rd;
    bit         err;
    rd  = 5'($urandom_range(1, 31));
    err = 1'b0;
    if (rand_faults) begin
      if ($urandom_range(0, 5) == 0) rd = '0;
      err = ($urandom_range(0, 7) == 0);
    end
    load_unit(i, $urandom, rd, err);
  endtask

  // What the next edge does, derived from the arbitration rules.
  task automatic model_step();
    int           winner;
    int           u;
    logic [N-1:0] masked;
    if (m_full && wb_ready) evq[0].push_back('{cyc, 32'(m_ent.rd), m_ent.data});
    if (!rst_n) begin
      m_full  = 1'b0;
      m_last  = N - 1;
      m_clear = '0;
      return;
    end
    if (flush) begin
      m_full  = 1'b0;
      m_clear = '1;
      evq[1].push_back('{cyc + 1, 32'hF, 32'h0});
      return;
    end
    masked = m_clear;
    winner = -1;
    if (!m_full || wb_ready) begin
      m_full = 1'b0;
      for (int k = 1; k <= N; k++) begin
        u = (m_last + k) % N;
        if (winner < 0 && upend[u] && !masked[u]) winner = u;
      end
    end
    m_clear = '0;
    if (winner >= 0) begin
      m_last          = winner;
      m_clear[winner] = 1'b1;
      evq[1].push_back('{cyc + 1, 32'(1 << winner), 32'h0});
      if (ue[winner].error) begin
        evq[2].push_back('{cyc + 1, 32'(winner), 32'(ue[winner].rd)});
      end else if (ue[winner].rd != 0) begin
        m_full = 1'b1;
        m_ent  = ue[winner];
      end
    end
  endtask

  // One cycle of stimulus: units react, inputs are driven, the model predicts the edge.
  task automatic tick(bit rdy, bit fl, bit rstn);
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (udrop[i]) begin
        udrop[i] = 1'b0;
        upend[i] = 1'b0;
        if (uregen[i] && $urandom_range(0, 99) < regen_pct) new_result(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_clear[i] && upend[i]) udrop[i] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (upend[i]) begin
        u_req[i]           = 1'b1;
        u_valid[i]         = 1'b1;
        u_error[i]         = ue[i].error;
        u_rd[i*AW +: AW]   = ue[i].rd;
        u_res[i*XW +: XW]  = ue[i].data;
      end else begin
        u_req[i]           = 1'($urandom_range(0, 1));
        u_valid[i]         = u_req[i] ? 1'b0 : 1'($urandom_range(0, 1));
        u_error[i]         = 1'($urandom_range(0, 1));
        u_rd[i*AW +: AW]   = 5'($urandom);
        u_res[i*XW +: XW]  = $urandom;
      end
    end
    wb_ready = rdy;
    flush    = fl;
    rst_n    = rstn;
    model_step();
  endtask

  task automatic match(int qi, bit seen, logic [31:0] a, logic [31:0] b);
    ev_t e;
    while (evq[qi].size() > 0 && evq[qi][0].cyc < cyc) begin
      e = evq[qi].pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing: required %h/%h in cycle %0d, actual none by cycle %0d",
               qname(qi), e.a, e.b, e.cyc, cyc);
    end
    if (seen) begin
      checks++;
      if (evq[qi].size() > 0 && evq[qi][0].cyc == cyc) begin
        e = evq[qi].pop_front();
        if (e.a !== a || e.b !== b) begin
          errors++;
          $display("FAIL %s cycle %0d: actual %h/%h required %h/%h", qname(qi), cyc, a, b, e.a, e.b);
        end
      end else begin
        errors++;
        $display("FAIL %s unexpected in cycle %0d: actual %h/%h, required none", qname(qi), cyc, a, b);
      end
    end
  endtask

  // Monitor: samples after the inputs for the next edge are settled.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_at_edge === 1'b0) begin
        checks++;
        if ({u_clear, wb_we, wb_addr, wb_data, exc_valid, exc_unit, exc_rd} !== '0) begin
          errors++;
          $display("FAIL reset_outputs cycle %0d: actual clr=%b we=%b addr=%h data=%h exc=%b unit=%h rd=%h required all zero",
                   cyc, u_clear, wb_we, wb_addr, wb_data, exc_valid, exc_unit, exc_rd);
        end
      end
      match(0, wb_we === 1'b1 && wb_ready === 1'b1, 32'(wb_addr), wb_data);
      match(1, u_clear !== '0, 32'(u_clear), 32'h0);
      match(2, exc_valid === 1'b1, 32'(exc_unit), 32'(exc_rd));
    end
  end

  initial begin
    rst_n    = 1'b0;
    wb_ready = 1'b1;
    flush    = 1'b0;
    u_req    = '0;
    u_valid  = '0;
    u_error  = '0;
    u_rd     = '0;
    u_res    = '0;
    for (int i = 0; i < N; i++) begin
      upend[i]  = 1'b0;
      udrop[i]  = 1'b0;
      uregen[i] = 1'b0;
      ue[i]     = '0;
    end

    // Reset
    repeat (3) tick(1, 0, 0);
    repeat (2) tick(1, 0, 1);

    // Single unit on ALU1
    load_unit(UNIT_ALU1, 32'hDEADBEEF, 5'd7, 1'b0);
    repeat (4) tick(1, 0, 1);

    // Round-robin among ALU0, SHIFT, MULDIV re-raising after each clear
    uregen[UNIT_ALU0]   = 1'b1;
    uregen[UNIT_SHIFT]  = 1'b1;
    uregen[UNIT_MULDIV] = 1'b1;
    load_unit(UNIT_ALU0,   32'h0000_0A00, 5'd1, 1'b0);
    load_unit(UNIT_SHIFT,  32'h0000_0C00, 5'd2, 1'b0);
    load_unit(UNIT_MULDIV, 32'h0000_0D00, 5'd3, 1'b0);
    repeat (12) tick(1, 0, 1);
    for (int i = 0; i < N; i++) uregen[i] = 1'b0;
    repeat (6) tick(1, 0, 1);

    // Backpressure: slot held, SHIFT waits, then drain and capture overlap
    load_unit(UNIT_ALU0, 32'h1111_0000, 5'd3, 1'b0);
    tick(1, 0, 1);
    load_unit(UNIT_SHIFT, 32'h2222_0000, 5'd4, 1'b0);
    repeat (3) tick(0, 0, 1);
    repeat (4) tick(1, 0, 1);

    // Exception from MULDIV, then an x0 result from ALU0
    load_unit(UNIT_MULDIV, 32'h3333_0000, 5'd9, 1'b1);
    load_unit(UNIT_ALU0,   32'h4444_0000, 5'd0, 1'b0);
    repeat (4) tick(1, 0, 1);

    // Flush with the slot full and ALU1/SHIFT requesting
    load_unit(UNIT_ALU0, 32'h5555_0000, 5'd5, 1'b0);
    tick(1, 0, 1);
    load_unit(UNIT_ALU1,  32'h6666_0000, 5'd6, 1'b0);
    load_unit(UNIT_SHIFT, 32'h7777_0000, 5'd8, 1'b0);
    tick(0, 0, 1);
    tick(0, 1, 1);
    repeat (3) tick(1, 0, 1);

    // Reset during a stall; ALU0 must win first afterwards
    load_unit(UNIT_SHIFT, 32'h8888_0000, 5'd6, 1'b0);
    tick(1, 0, 1);
    load_unit(UNIT_ALU1, 32'h9999_0000, 5'd8, 1'b0);
    repeat (2) tick(0, 0, 1);
    tick(0, 0, 0);
    load_unit(UNIT_ALU0,   32'hAAAA_0000, 5'd10, 1'b0);
    load_unit(UNIT_MULDIV, 32'hBBBB_0000, 5'd11, 1'b0);
    repeat (6) tick(1, 0, 1);

    // Random traffic with errors, x0, stalls, flushes and resets
    rand_faults = 1'b1;
    regen_pct   = 60;
    for (int i = 0; i < N; i++) begin
      uregen[i] = 1'b1;
      new_result(i);
    end
    for (int c = 0; c < 2000; c++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 199) != 0);
    end

    // Drain
    for (int i = 0; i < N; i++) uregen[i] = 1'b0;
    repeat (16) tick(1, 0, 1);
    @(negedge clk);
    #5;
    for (int qi = 0; qi < 3; qi++) begin
      while (evq[qi].size() > 0) begin
        ev_t e;
        e = evq[qi].pop_front();
        checks++;
        errors++;
        $display("FAIL %s missing at end: required %h/%h in cycle %0d, actual none", qname(qi), e.a, e.b, e.cyc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_arbiter.md
# commit_arbiter

- Collects completed results from up to `N_UNITS` execution units: the set-less-than/branch-condition ALU, the arithmetic ALU, the shifter and the mul/div unit.
- Round-robin arbitration picks one winner per cycle and buffers it in a one-entry writeback register.
- Drives the single register-file write port and the exception line.
- Returns a `clear` pulse to the unit it consumed.

## Interface
- `N_UNITS`, default 4: number of execution units arbitrated; range 2..8.
- `XLEN`, default `core_config_pkg::XLEN` (32): data width.
- `REG_ADDR_W`, default `core_config_pkg::REG_ADDR_W` (5): register address width.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `u_res`  in  N_UNITS×XLEN  result from each unit.
- `u_rd`  in  N_UNITS×REG_ADDR_W  destination register from each unit.
- `u_valid`  in  N_UNITS  the unit's result is valid.
- `u_error`  in  N_UNITS  the unit's result is an error.
- `u_req`  in  N_UNITS  the unit requests commit.
- `u_clear`  out  N_UNITS  one-cycle pulse: the unit's result has been consumed.
- `wb_ready`  in  1  the register-file port accepts this cycle.
- `wb_we`  out  1  write enable.
- `wb_addr`  out  REG_ADDR_W  write address.
- `wb_data`  out  XLEN  write data.
- `exc_valid`  out  1  one-cycle exception pulse.
- `exc_unit`  out  3  index of the unit that raised the error.
- `exc_rd`  out  REG_ADDR_W  rd of the erroring result.
- `flush`  in  1  discard all in-flight results.

## Operation
- A unit is a candidate when `u_req[i] & u_valid[i]` is high and `i` is not masked.
- The masked unit is the one whose `u_clear` is asserted in the current cycle.
- The writeback register (`wb_full`) can load when it is empty, or when `wb_full & wb_ready` drains it in the same cycle.
- When it can load and a candidate exists:
  - Grant goes round-robin, starting at `last_grant+1` and wrapping from `N_UNITS-1` to 0.
  - At the edge the winner's res/rd/error are captured.
  - `last_grant` is updated to the winner.
  - `u_clear[winner]` is registered high for exactly the next cycle.
- The winning entry is then handled as follows:
  - **error = 1:** not written. `exc_valid` pulses in the capture+1 cycle with `exc_unit` and `exc_rd`. The slot stays empty.
  - **rd = 0:** discarded, with no write. The unit is still cleared.
  - **otherwise:** the entry is held in the writeback register. `wb_we` = `wb_full`. It stays stable until `wb_ready`.
- `flush`, which has priority over all other events:
  - Invalidates the writeback register at the next edge.
  - Suppresses grant that cycle.
  - Registers `u_clear` all-ones for one cycle.
  - `last_grant` is unchanged.
- A unit drops `req` the cycle after it sees `clear`. Masking prevents a double grant during that cycle.

## Timing
- All outputs reset low/zero while `rst_n` = 0 at the edge: `u_clear`, `wb_we`, `wb_addr`, `wb_data`, `exc_valid`, `exc_unit`, `exc_rd`.
- After reset, `wb_full` = 0 and `last_grant` = `N_UNITS-1`, so unit 0 has first priority.
- Latency from candidate (cycle T, slot free) to result: `wb_we`, `u_clear` or `exc_valid` is high in T+1.
- A write completes at the first edge with `wb_we & wb_ready`.
- Throughput is 1 commit/cycle when `wb_ready` is held high.
- While `wb_ready` = 0 and the slot is full, there are no grants, no clears, and `wb_*` is held.
- If drain and load happen in the same cycle, the new entry replaces the old one with no bubble.
- Reset asserted mid-operation drops the buffered entry and pending clears at the next edge.

## Structure
- `core_config_pkg` gets:
  - `COMMIT_UNITS` constant.
  - `commit_entry_t` struct {data, rd, error}.
  - Unit index enum: `UNIT_ALU0`, `UNIT_ALU1`, `UNIT_SHIFT`, `UNIT_MULDIV`.
- Sub-module `rr_arbiter`, parameterised by N:
  - Inputs: request vector and `advance`.
  - Outputs: one-hot grant and encoded index.
  - Owns `last_grant`.
- The `commit_arbiter` top holds the writeback register, clear/exception registers and flush logic.

## Test plan
- **Single unit:** unit 1 req/valid with res=0xDEADBEEF, rd=7, `wb_ready`=1. Expect `wb_we`/addr=7/data=0xDEADBEEF and `u_clear[1]` both high in the next cycle, and no second grant.
- **Round-robin:** units 0, 2, 3 requesting continuously, each re-raising after clear. Expect grant order 0, 2, 3, 0, 2, 3 with `last_grant` wrapping.
- **Backpressure:** unit 0 captured, `wb_ready`=0 for 3 cycles while unit 2 requests. Expect `wb_*` held and no `u_clear[2]`. When `wb_ready`=1, expect unit 2 captured the same cycle as the drain.
- **Error and x0:** unit 3 error=1, rd=9. Expect `exc_valid`=1, `exc_unit`=3, `exc_rd`=9, `wb_we`=0. A unit 0 result with rd=0 gives `u_clear[0]`=1 and `wb_we`=0.
- **Flush:** `flush` while the slot is full and units 1 and 2 are requesting. Expect `wb_we`=0 and `u_clear`=all-ones the next cycle, with no grant.
- **Reset mid-stall:** assert `rst_n`=0 during backpressure. Expect all outputs zero after the edge and unit 0 to win first afterwards.
